// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a skid register for a stalled decode, and redirects.
// Optional FETCH_SUPERVISOR_EN: fetch_pc[31] becomes a supervisor bit that is never sent to memory.
module fetch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] br_addr,
  input  logic [31:0] j_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        ir_valid
);
  localparam logic [31:0] NOP       = 32'h83FF_F800;
  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP     = 32'h8000_0004;
  localparam logic [31:0] XADR      = 32'h8000_0008;

  typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_HOLD} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q, old_addr_q, ir_q, pc_q, skid_ir_q, skid_pc_q;
  logic        ir_valid_q;
  logic        redirect;
  logic [31:0] target_d, seq_pc_d, fetch_addr;

`ifdef FETCH_SUPERVISOR_EN
  assign seq_pc_d   = {fetch_pc_q[31], fetch_pc_q[30:0] + 31'd4};
  assign fetch_addr = {1'b0, fetch_pc_q[30:2], 2'b00};
`else
  assign seq_pc_d   = fetch_pc_q + 32'd4;
  assign fetch_addr = {fetch_pc_q[31:2], 2'b00};
`endif

  always_comb begin
    redirect = 1'b1;
    target_d = fetch_pc_q;
    case (pc_sel)
`ifdef FETCH_SUPERVISOR_EN
      3'd1:    target_d = {fetch_pc_q[31], br_addr[30:0]};
      3'd2:    target_d = {fetch_pc_q[31] & j_addr[31], j_addr[30:0]};
`else
      3'd1:    target_d = br_addr;
      3'd2:    target_d = j_addr;
`endif
      3'd3:    target_d = ILLOP;
      3'd4:    target_d = XADR;
      default: redirect = 1'b0;
    endcase
  end

  // DISCARD keeps presenting the abandoned address until its response arrives.
  assign imem_req  = (state_q != S_HOLD);
  assign imem_addr = (state_q == S_DISCARD) ? old_addr_q : fetch_addr;
  assign ir        = ir_q;
  assign pc        = pc_q;
  assign ir_valid  = ir_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_VEC;
      old_addr_q <= RESET_VEC;
      ir_q       <= NOP;
      pc_q       <= RESET_VEC;
      ir_valid_q <= 1'b0;
      skid_ir_q  <= NOP;
      skid_pc_q  <= RESET_VEC;
    end else if (redirect) begin
      fetch_pc_q <= target_d;
      ir_q       <= NOP;
      ir_valid_q <= 1'b0;
      skid_ir_q  <= NOP;
      if (state_q == S_FETCH) old_addr_q <= fetch_addr;
      state_q <= (state_q != S_HOLD && !imem_ack) ? S_DISCARD : S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_ack) begin
            fetch_pc_q <= seq_pc_d;
            if (stall) begin
              skid_ir_q <= imem_rdata;
              skid_pc_q <= seq_pc_d;
              state_q   <= S_HOLD;
            end else begin
              ir_q       <= imem_rdata;
              pc_q       <= seq_pc_d;
              ir_valid_q <= 1'b1;
            end
          end else if (!stall) begin
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ir_q       <= skid_ir_q;
            pc_q       <= skid_pc_q;
            ir_valid_q <= 1'b1;
            state_q    <= S_FETCH;
          end
        end
        S_DISCARD: begin
          if (!stall) begin
            ir_q       <= NOP;
            ir_valid_q <= 1'b0;
          end
          if (imem_ack) state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cycle table, a long-stall sequence, then random traffic against
// an instruction-stream model (every delivered word must be the next expected address's word).
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h83FF_F800;
  localparam logic [31:0] RV  = 32'h8000_0000;
`ifdef FETCH_SUPERVISOR_EN
  localparam logic [31:0] WRAP_ADDR = 32'h7FFF_FFFC;
  localparam logic [31:0] WRAP_PC0  = 32'h8000_0000;
  localparam logic [31:0] WRAP_PC1  = 32'h8000_0004;
`else
  localparam logic [31:0] WRAP_ADDR = 32'hFFFF_FFFC;
  localparam logic [31:0] WRAP_PC0  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC1  = 32'h0000_0004;
`endif

  logic        clk = 1'b0, rst, stall, imem_req, imem_ack, ir_valid;
  logic [2:0]  pc_sel;
  logic [31:0] br_addr, j_addr, imem_addr, imem_rdata, pc, ir;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_sel(pc_sel), .br_addr(br_addr), .j_addr(j_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .ir(ir), .ir_valid(ir_valid)
  );

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic rst, stall; logic [2:0] sel; logic [31:0] br, j; logic ack; logic [31:0] rd;
    logic pre, req; logic [31:0] addr, ir, pc; logic vld;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic [2:0] sel, logic [31:0] br, logic [31:0] j,
                              logic ack, logic [31:0] rd, logic pre, logic req, logic [31:0] addr,
                              logic [31:0] e_ir, logic [31:0] e_pc, logic vld);
    vec_t v;
    v.rst = r; v.stall = s; v.sel = sel; v.br = br; v.j = j; v.ack = ack; v.rd = rd;
    v.pre = pre; v.req = req; v.addr = addr; v.ir = e_ir; v.pc = e_pc; v.vld = vld;
    return v;
  endfunction

  // Reference model helpers, computed from the architectural rules.
  function automatic logic [31:0] m_inc(logic [31:0] a);
`ifdef FETCH_SUPERVISOR_EN
    return ((a + 32'd4) & 32'h7FFF_FFFF) | (a & 32'h8000_0000);
`else
    return a + 32'd4;
`endif
  endfunction

  function automatic logic [31:0] m_phys(logic [31:0] a);
`ifdef FETCH_SUPERVISOR_EN
    return a & 32'h7FFF_FFFC;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic [31:0] m_tgt(logic [2:0] sel, logic [31:0] cur, logic [31:0] br, logic [31:0] j);
    logic [31:0] t;
    case (sel)
`ifdef FETCH_SUPERVISOR_EN
      3'd1: t = (cur & 32'h8000_0000) | (br & 32'h7FFF_FFFF);
      3'd2: t = (cur & j & 32'h8000_0000) | (j & 32'h7FFF_FFFF);
`else
      3'd1: t = br;
      3'd2: t = j;
`endif
      3'd3: t = 32'h8000_0004;
      default: t = 32'h8000_0008;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] exp_next, o_ir, o_pc, p_addr;
    logic        o_vld, p_req, p_ack, p_rst;
    int          deliveries;

    rst = 1'b1; stall = 1'b0; pc_sel = 3'd0; br_addr = '0; j_addr = '0;
    imem_ack = 1'b0; imem_rdata = '0;

    //                rst s sel br            j      ack rdata  pre req addr         ir       pc           vld
    tbl.push_back(mk(1, 0, 0, 0,            0,     0, 0,     0,  0, 0,           NOP,     RV,          0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'h11,  1,  1, RV,          'h11,    32'h80000004, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'h22,  1,  1, 32'h80000004, 'h22,   32'h80000008, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0, 0,     1,  1, 32'h80000008, NOP,    32'h80000008, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0, 0,     1,  1, 32'h80000008, NOP,    32'h80000008, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0, 0,     1,  1, 32'h80000008, NOP,    32'h80000008, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'h33,  1,  1, 32'h80000008, 'h33,   32'h8000000C, 1));
    tbl.push_back(mk(0, 1, 0, 0,            0,     1, 'h44,  1,  1, 32'h8000000C, 'h33,   32'h8000000C, 1));
    tbl.push_back(mk(0, 1, 0, 0,            0,     0, 0,     1,  0, 32'h80000010, 'h33,   32'h8000000C, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0, 0,     1,  0, 32'h80000010, 'h44,   32'h80000010, 1));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'h55,  1,  1, 32'h80000010, 'h55,   32'h80000014, 1));
    tbl.push_back(mk(0, 0, 1, 32'h80000100, 0,     0, 0,     1,  1, 32'h80000014, NOP,    32'h80000014, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     0, 0,     1,  1, 32'h80000014, NOP,    32'h80000014, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'h66,  1,  1, 32'h80000014, NOP,    32'h80000014, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'h77,  1,  1, 32'h80000100, 'h77,   32'h80000104, 1));
    tbl.push_back(mk(0, 0, 3, 0,            0,     1, 'h88,  1,  1, 32'h80000104, NOP,    32'h80000104, 0));
    tbl.push_back(mk(0, 0, 4, 0,            0,     0, 0,     1,  1, 32'h80000004, NOP,    32'h80000104, 0));
    tbl.push_back(mk(0, 0, 2, 0,            'h40,  0, 0,     1,  1, 32'h80000004, NOP,    32'h80000104, 0));
    tbl.push_back(mk(1, 0, 0, 0,            0,     1, 'h99,  1,  1, 32'h80000004, NOP,    RV,           0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'hAA,  1,  1, RV,          'hAA,    32'h80000004, 1));
    tbl.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0,     1, 'hBB,  1,  1, 32'h80000004, NOP,    32'h80000004, 0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'hCC,  1,  1, WRAP_ADDR,   'hCC,    WRAP_PC0,     1));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'hDD,  1,  1, 0,           'hDD,    WRAP_PC1,     1));
    tbl.push_back(mk(0, 1, 0, 0,            0,     1, 'hEE,  1,  1, 4,           'hDD,    WRAP_PC1,     1));
    tbl.push_back(mk(0, 1, 1, 32'h80000200, 0,     0, 0,     1,  0, 8,           NOP,     WRAP_PC1,     0));
    tbl.push_back(mk(0, 0, 0, 0,            0,     1, 'hF1,  1,  1, 32'h80000200, 'hF1,   32'h80000204, 1));
    tbl.push_back(mk(0, 1, 0, 0,            0,     0, 0,     1,  1, 32'h80000204, 'hF1,   32'h80000204, 1));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; stall = tbl[i].stall; pc_sel = tbl[i].sel; br_addr = tbl[i].br;
      j_addr = tbl[i].j; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rd;
      #1;
      if (tbl[i].pre) begin
        chk($sformatf("v%0d.req", i), {31'd0, imem_req}, {31'd0, tbl[i].req});
        chk($sformatf("v%0d.addr", i), imem_addr, tbl[i].addr);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d.ir", i), ir, tbl[i].ir);
      chk($sformatf("v%0d.pc", i), pc, tbl[i].pc);
      chk($sformatf("v%0d.vld", i), {31'd0, ir_valid}, {31'd0, tbl[i].vld});
    end

    // Long stall: skid word must surface exactly once, with no request while holding.
    @(negedge clk);
    rst = 0; stall = 1; pc_sel = 0; imem_ack = 1; imem_rdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      chk("hold.req", {31'd0, imem_req}, 32'd0);
      chk("hold.ir", ir, 32'h0000_00F1);
    end
    stall = 1'b0;
    @(posedge clk); #1;
    chk("hold.rel_ir", ir, 32'h1234_5678);
    chk("hold.rel_pc", pc, 32'h8000_0208);
    @(negedge clk);
    chk("hold.addr_next", imem_addr, 32'h8000_0208);
    @(posedge clk); #1;
    chk("hold.no_dup", {31'd0, ir_valid}, 32'd0);

    // Random traffic against the stream model.
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; pc_sel = 3'd0;
    @(posedge clk); #1;
    exp_next = RV; deliveries = 0;
    p_rst = 1'b1; p_req = 1'b0; p_ack = 1'b0; p_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!p_rst && p_req && !p_ack) chk("rnd.addr_stable", imem_addr, p_addr);
      o_ir = ir; o_pc = pc; o_vld = ir_valid;
      rst      = ($urandom % 100) == 0;
      stall    = ($urandom % 4) == 0;
      pc_sel   = (($urandom % 10) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      br_addr  = $urandom & 32'hFFFF_FFFC;
      j_addr   = $urandom & 32'hFFFF_FFFC;
      imem_ack = imem_req && ($urandom % 2 == 1);
      imem_rdata = mem_word(imem_addr);
      p_rst = rst; p_req = imem_req; p_ack = imem_ack; p_addr = imem_addr;
      @(posedge clk); #1;
      if (rst) begin
        exp_next = RV;
        chk("rnd.rst_ir", ir, NOP);
        chk("rnd.rst_pc", pc, RV);
        chk("rnd.rst_vld", {31'd0, ir_valid}, 32'd0);
      end else if (pc_sel >= 3'd1 && pc_sel <= 3'd4) begin
        exp_next = m_tgt(pc_sel, exp_next, br_addr, j_addr);
        chk("rnd.redir_ir", ir, NOP);
        chk("rnd.redir_vld", {31'd0, ir_valid}, 32'd0);
      end else if (stall) begin
        chk("rnd.stall_ir", ir, o_ir);
        chk("rnd.stall_pc", pc, o_pc);
        chk("rnd.stall_vld", {31'd0, ir_valid}, {31'd0, o_vld});
      end else if (ir_valid) begin
        chk("rnd.pc", pc, m_inc(exp_next));
        chk("rnd.ir", ir, mem_word(m_phys(exp_next)));
        exp_next = m_inc(exp_next);
        deliveries++;
      end else begin
        chk("rnd.bubble_ir", ir, NOP);
      end
    end
    chk("rnd.deliveries_min", {31'd0, deliveries >= 200}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  reset; one clock, reset synchronous and active-high.
REQ-003 SHALL have: stall  in  1  decode-stage stall; hold decode-facing outputs.
REQ-004 SHALL have: pc_sel  in  3  next-PC select: 0 sequential, 1 br_addr, 2 j_addr, 3 ILLOP, 4 XADR; 5-7 treated as 0.
REQ-005 SHALL have: br_addr  in  32  branch target; j_addr  in  32  jump target.
REQ-006 SHALL have: imem_req  out  1  instruction fetch request; imem_addr  out  32  word address, [1:0]=0.
REQ-007 SHALL have: imem_ack  in  1  response valid (same-cycle ack allowed); imem_rdata  in  32  instruction word.
REQ-008 SHALL have: pc  out  32  PC+4 of instruction on ir; ir  out  32  instruction to decode; ir_valid  out  1  ir holds a fetched instruction.
REQ-009 SHALL define constants: NOP = 32'h83FF_F800 (ADD R31,R31,R31), RESET_VEC = 32'h8000_0000, ILLOP = 32'h8000_0004, XADR = 32'h8000_0008.

Function
REQ-010 SHALL hold internal fetch_pc; imem_addr = {fetch_pc[31:2],2'b00}, stable while imem_req=1 and imem_ack=0.
REQ-011 SHALL implement states FETCH (req=1), DISCARD (req=1, response dropped), HOLD (req=0, response buffered in skid register).
REQ-012 FETCH, ack=1, stall=0, pc_sel=0: next cycle ir=imem_rdata, pc=fetch_pc+4, ir_valid=1; fetch_pc+=4; stay FETCH. Latency: ack edge to ir valid = 1 cycle.
REQ-013 FETCH, ack=0, stall=0: ir=NOP, ir_valid=0, pc held.
REQ-014 stall=1 with pc_sel=0: ir, pc, ir_valid SHALL hold; ack in FETCH captures rdata and fetch_pc+4 into skid, fetch_pc+=4, go HOLD.
REQ-015 HOLD, stall=0: ir=skid, pc=skid pc, ir_valid=1; go FETCH.
REQ-016 pc_sel!=0 (redirect) SHALL take priority over stall: fetch_pc=target next cycle; ir=NOP, ir_valid=0; skid discarded.
REQ-017 Redirect in FETCH with ack=0: go DISCARD; keep old imem_addr until ack; drop that response; then FETCH at target.
REQ-018 Redirect with ack=1 same cycle, or from HOLD: response dropped, go FETCH at target next cycle.
REQ-019 Redirect in DISCARD: update target only; remain DISCARD until ack.
REQ-020 Sequential increment SHALL wrap 32'hFFFF_FFFC -> 0 (subject to REQ-025).
REQ-021 At most one request outstanding; no new address presented before ack.

Reset
REQ-022 rst=1 SHALL set: fetch_pc=RESET_VEC, state=FETCH, ir=NOP, pc=RESET_VEC, ir_valid=0, skid cleared.
REQ-023 rst mid-transaction SHALL abandon outstanding request: response acked at or after reset edge is ignored; first cycle after rst deassert presents RESET_VEC with req=1.

Configuration
REQ-024 Macro FETCH_SUPERVISOR_EN SHALL select supervisor-bit handling.
REQ-025 Defined: fetch_pc[31] is supervisor bit; sequential increment and branch preserve bit 31; jump takes j_addr[31] AND current bit 31 (may clear, never set); ILLOP/XADR/reset set it; imem_addr[31]=0.
REQ-026 Undefined: bit 31 is ordinary address bit; all targets used unmodified; imem_addr = fetch_pc.

Verification
REQ-027 Reset release, ack every cycle, rdata=0x11,0x22 -> imem_addr 0x80000000,0x80000004; ir 0x11 then 0x22, pc 0x80000004,0x80000008, ir_valid=1.
REQ-028 ack delayed 3 cycles -> imem_addr stable; ir=NOP, ir_valid=0 for those cycles; then instruction with correct pc.
REQ-029 stall=1 for 2 cycles, ack during stall -> ir/pc unchanged, req=0 in HOLD; after release skid instruction appears once, none lost or duplicated.
REQ-030 pc_sel=1, br_addr=0x80000100 while request outstanding -> old response dropped, ir=NOP, next imem_addr=0x80000100.
REQ-031 FETCH_SUPERVISOR_EN defined, supervisor clear, pc_sel=2, j_addr=0x80000040 -> fetch_pc=0x00000040; pc_sel=3 -> fetch_pc=0x80000004.
REQ-032 rst asserted in DISCARD with late ack -> ack ignored, fetch restarts at RESET_VEC, ir=NOP.
